fifo2apb_master: RTL and testbench

//  APB initiator that drains command words from an async command FIFO and issues APB

---
 rtl/fifo2apb_master.sv | 143 ++++++++++++++
 tb/tb_fifo2apb_master.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2apb_master.sv
// fifo2apb_master: pops command words, runs one APB transfer each and
// pushes {status, rdata} responses. Optional macro: WRITE_RSP_EN.
module fifo2apb_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     cmd_empty,
  input  logic [ADDR_W+DATA_W:0]   cmd_data,
  output logic                     cmd_read_inc,
  input  logic                     rsp_full,
  output logic [DATA_W+1:0]        rsp_write_data,
  output logic                     rsp_write_inc,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic                     pready,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pslverr,
  output logic                     busy,
  output logic [7:0]               timeout_cnt
);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TO  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_SETUP  = 4'b0010,
    S_ACCESS = 4'b0100,
    S_RESP   = 4'b1000
  } state_t;

  state_t            r_state;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_cmd_ok;
  logic              w_cmd_wr;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic              w_to_hit;
  logic [1:0]        w_status;

  // Response space is reserved before popping, so a push never stalls.
  assign w_cmd_ok    = !cmd_empty && !rsp_full;
  assign w_cmd_wr    = cmd_data[ADDR_W+DATA_W];
  assign w_cmd_addr  = cmd_data[ADDR_W+DATA_W-1:DATA_W];
  assign w_cmd_wdata = cmd_data[DATA_W-1:0];
  assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_status    = pslverr ? ST_ERR : ST_OK;

  // Transfer sequencer; every output is a flop updated here.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state        <= S_IDLE;
      r_to_cnt       <= '0;
      cmd_read_inc   <= 1'b0;
      rsp_write_data <= '0;
      rsp_write_inc  <= 1'b0;
      paddr          <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      busy           <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      cmd_read_inc  <= 1'b0;
      rsp_write_inc <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cmd_ok) begin
            cmd_read_inc <= 1'b1;
            paddr        <= w_cmd_addr;
            pwrite       <= w_cmd_wr;
            pwdata       <= w_cmd_wdata;
            psel         <= 1'b1;
            busy         <= 1'b1;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable  <= 1'b1;
          r_to_cnt <= '0;
          r_state  <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            if (!pwrite) begin
              rsp_write_data <= {w_status, prdata};
              rsp_write_inc  <= 1'b1;
              r_state        <= S_RESP;
            end else begin
`ifdef WRITE_RSP_EN
              rsp_write_data <= {w_status, {DATA_W{1'b0}}};
              rsp_write_inc  <= 1'b1;
              r_state        <= S_RESP;
`else
              busy    <= 1'b0;
              r_state <= S_IDLE;
`endif
            end
          end else if (w_to_hit) begin
            psel           <= 1'b0;
            penable        <= 1'b0;
            paddr          <= '0;
            pwrite         <= 1'b0;
            pwdata         <= '0;
            rsp_write_data <= {ST_TO, {DATA_W{1'b0}}};
            rsp_write_inc  <= 1'b1;
            if (timeout_cnt != 8'hFF)
              timeout_cnt <= timeout_cnt + 8'd1;
            r_state <= S_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2apb_master.sv
// Bench for fifo2apb_master: FIFO and APB slave models, monitors and
// a transaction-level reference for responses, latency and timeouts.
module tb_fifo2apb_master;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef WRITE_RSP_EN
  localparam bit WRSP = 1'b1;
`else
  localparam bit WRSP = 1'b0;
`endif

  logic           pclk = 1'b0;
  logic           preset_n = 1'b0;
  logic           cmd_empty = 1'b1;
  logic [AW+DW:0] cmd_data = '0;
  logic           cmd_read_inc;
  logic           rsp_full = 1'b0;
  logic [DW+1:0]  rsp_write_data;
  logic           rsp_write_inc;
  logic [AW-1:0]  paddr;
  logic           psel, penable, pwrite;
  logic [DW-1:0]  pwdata;
  logic           pready = 1'b0;
  logic [DW-1:0]  prdata = '0;
  logic           pslverr = 1'b0;
  logic           busy;
  logic [7:0]     timeout_cnt;

  always #5 pclk = ~pclk;

  fifo2apb_master dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_empty(cmd_empty), .cmd_data(cmd_data),
    .cmd_read_inc(cmd_read_inc), .rsp_full(rsp_full),
    .rsp_write_data(rsp_write_data), .rsp_write_inc(rsp_write_inc),
    .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    int            waits;
    logic          err;
    logic [DW-1:0] rd;
  } beh_t;
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            setup;
    int            acc;
  } txn_t;
  typedef struct {
    int            cyc;
    logic [DW+1:0] d;
  } rsp_t;
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    beh_t          b;
  } iss_t;

  logic [AW+DW:0] cmdq[$];
  beh_t           slvq[$];
  txn_t           txq[$];
  rsp_t           rspq[$];
  int             popq[$];
  iss_t           issq[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   stab_err = 0;
  int   idle_err = 0;
  int   exp_to = 0;
  beh_t cur;
  txn_t tcur;
  logic in_tx = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  // FIFO model, APB slave model and bus monitors
  always @(negedge pclk) begin
    if (rsp_write_inc) rspq.push_back('{cyc, rsp_write_data});
    if (cmd_read_inc) begin
      popq.push_back(cyc);
      if (cmdq.size() > 0) cmdq.delete(0);
    end
    cmd_empty = (cmdq.size() == 0);
    cmd_data  = cmd_empty ? '0 : cmdq[0];
    if (psel && !penable) begin
      if (slvq.size() > 0) cur = slvq.pop_front();
      else cur = '{0, 1'b0, '0};
      tcur    = '{pwrite, paddr, pwdata, cyc, 0};
      in_tx   = 1'b1;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end else if (psel && penable) begin
      tcur.acc++;
      if ({pwrite, paddr, pwdata} !== {tcur.wr, tcur.a, tcur.wd})
        stab_err++;
      pready  = (tcur.acc > cur.waits);
      pslverr = cur.err;
      prdata  = pready ? cur.rd : DW'($urandom);
    end else begin
      if (in_tx) begin
        txq.push_back(tcur);
        in_tx = 1'b0;
      end
      if (!busy && ({pwrite, paddr, pwdata} !== '0)) idle_err++;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end
  end

  function automatic bit model_rsp(input iss_t s, output logic [DW+1:0] r);
    if (s.b.waits >= TO) begin
      r = {2'b10, {DW{1'b0}}};
      return 1'b1;
    end
    r = {1'b0, s.b.err, s.wr ? {DW{1'b0}} : s.b.rd};
    return !s.wr || WRSP;
  endfunction

  function automatic int model_acc(input iss_t s);
    return (s.b.waits >= TO) ? TO : s.b.waits + 1;
  endfunction

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input int waits,
                       input logic err, input logic [DW-1:0] rd);
    beh_t b;
    b = '{waits, err, rd};
    slvq.push_back(b);
    cmdq.push_back({wr, a, wd});
    issq.push_back('{wr, a, wd, b});
    if (waits >= TO && exp_to < 255) exp_to++;
  endtask

  task automatic drain(output bit ok);
    int n;
    int lim;
    n = 0;
    lim = 40 + 24 * (cmdq.size() + 1);
    do begin
      @(posedge pclk);
      #1;
      n++;
    end while ((cmdq.size() != 0 || busy || rsp_write_inc) && n < lim);
    ok = (n < lim);
    repeat (2) @(negedge pclk);
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_logs();
    txq.delete();
    rspq.delete();
    popq.delete();
    issq.delete();
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({cmd_read_inc, rsp_write_data, rsp_write_inc, paddr, psel, penable,
         pwrite, pwdata, busy, timeout_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got psel=%b busy=%b rsp=%0h to=%0d exp all 0",
               psel, busy, rsp_write_data, timeout_cnt);
    end
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({psel, busy, cmd_read_inc} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got psel=%b busy=%b pop=%b exp 0",
               psel, busy, cmd_read_inc);
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    issue(1'b0, 16'h0003, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0300);
    drain(ok);
    checks++;
    if (!ok || popq.size() != 1) begin
      failures++;
      $display("FAIL read_pop got ok=%0b pops=%0d exp ok=1 pops=1", ok, popq.size());
    end
    checks++;
    if (txq.size() != 1 || txq[0].wr !== 1'b0 || txq[0].a !== 16'h0003 ||
        txq[0].acc != 1) begin
      failures++;
      $display("FAIL read_apb got n=%0d exp one read to addr 3, 1 access", txq.size());
    end
    checks++;
    if (rspq.size() != 1 || rspq[0].d !== {2'b00, 32'h0000_0300}) begin
      failures++;
      $display("FAIL read_rsp got n=%0d d=%0h exp 1 x 0300",
               rspq.size(), rspq.size() > 0 ? rspq[0].d : '0);
    end
    checks++;
    if (rspq.size() != 1 || txq.size() != 1 || rspq[0].cyc != txq[0].setup + 2) begin
      failures++;
      $display("FAIL read_latency got push-setup=%0d exp 2",
               (rspq.size() > 0 && txq.size() > 0) ? rspq[0].cyc - txq[0].setup : -1);
    end
    checks++;
    if (rsp_write_data !== {2'b00, 32'h0000_0300}) begin
      failures++;
      $display("FAIL read_rsp_hold got %0h exp 0300", rsp_write_data);
    end
  endtask

  task automatic test_write();
    bit ok;
    clear_logs();
    issue(1'b1, 16'h0001, 32'h0000_00A5, 0, 1'b0, $urandom);
    drain(ok);
    checks++;
    if (!ok || txq.size() != 1 || txq[0].wr !== 1'b1 || txq[0].a !== 16'h0001 ||
        txq[0].wd !== 32'h0000_00A5 || stab_err != 0) begin
      failures++;
      $display("FAIL write_apb got ok=%0b n=%0d stab=%0d exp A5 to addr 1",
               ok, txq.size(), stab_err);
    end
    checks++;
    if (rspq.size() != int'(WRSP)) begin
      failures++;
      $display("FAIL write_rsp_count got %0d exp %0d", rspq.size(), int'(WRSP));
    end
    if (rspq.size() > 0) begin
      checks++;
      if (rspq[0].d !== '0) begin
        failures++;
        $display("FAIL write_rsp_data got %0h exp 0", rspq[0].d);
      end
    end
  endtask

  task automatic test_wait_err();
    bit ok;
    logic [DW-1:0] rd;
    rd = $urandom;
    clear_logs();
    issue(1'b0, AW'($urandom), $urandom, 3, 1'b1, rd);
    drain(ok);
    checks++;
    if (!ok || txq.size() != 1 || txq[0].acc != 4) begin
      failures++;
      $display("FAIL wait_penable got ok=%0b acc=%0d exp 4",
               ok, txq.size() > 0 ? txq[0].acc : -1);
    end
    checks++;
    if (rspq.size() != 1 || rspq[0].d !== {2'b01, rd} ||
        txq.size() != 1 || rspq[0].cyc != txq[0].setup + 5) begin
      failures++;
      $display("FAIL wait_err_rsp got n=%0d d=%0h exp 1 x %0h",
               rspq.size(), rspq.size() > 0 ? rspq[0].d : '0, {2'b01, rd});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [DW-1:0] rd;
    checks++;
    if (timeout_cnt !== 8'd0) begin
      failures++;
      $display("FAIL timeout_pre got %0d exp 0", timeout_cnt);
    end
    clear_logs();
    issue(1'b1, AW'($urandom), $urandom, 100, 1'b0, $urandom);
    drain(ok);
    checks++;
    if (!ok || txq.size() != 1 || txq[0].acc != TO) begin
      failures++;
      $display("FAIL timeout_access got acc=%0d exp %0d",
               txq.size() > 0 ? txq[0].acc : -1, TO);
    end
    checks++;
    if (rspq.size() != 1 || rspq[0].d !== {2'b10, 32'h0} || timeout_cnt !== 8'd1) begin
      failures++;
      $display("FAIL timeout_write got n=%0d to=%0d exp push 10/0 to=1",
               rspq.size(), timeout_cnt);
    end
    clear_logs();
    issue(1'b0, AW'($urandom), $urandom, TO, 1'b1, $urandom);
    drain(ok);
    checks++;
    if (rspq.size() != 1 || rspq[0].d !== {2'b10, 32'h0} || timeout_cnt !== 8'd2) begin
      failures++;
      $display("FAIL timeout_read got n=%0d d=%0h to=%0d exp 10/0 to=2",
               rspq.size(), rspq.size() > 0 ? rspq[0].d : '0, timeout_cnt);
    end
    rd = $urandom;
    clear_logs();
    issue(1'b0, AW'($urandom), $urandom, TO - 1, 1'b0, rd);
    drain(ok);
    checks++;
    if (rspq.size() != 1 || rspq[0].d !== {2'b00, rd} || timeout_cnt !== 8'd2 ||
        txq.size() != 1 || txq[0].acc != TO) begin
      failures++;
      $display("FAIL timeout_edge got n=%0d d=%0h to=%0d exp %0h to=2",
               rspq.size(), rspq.size() > 0 ? rspq[0].d : '0, timeout_cnt, {2'b00, rd});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int rel;
    clear_logs();
    rsp_full = 1'b1;
    issue(1'b0, AW'($urandom), $urandom, 0, 1'b0, $urandom);
    repeat (6) @(posedge pclk);
    #1;
    checks++;
    if (popq.size() != 0 || busy !== 1'b0 || psel !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got pops=%0d busy=%b exp 0 0", popq.size(), busy);
    end
    rsp_full = 1'b0;
    rel = cyc;
    drain(ok);
    checks++;
    if (!ok || txq.size() != 1 || popq.size() != 1 || txq[0].setup != rel + 1) begin
      failures++;
      $display("FAIL bp_release got setup=%0d exp %0d",
               txq.size() > 0 ? txq[0].setup : -1, rel + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    for (int i = 0; i < 3; i++)
      issue(1'b0, AW'($urandom), $urandom, 0, 1'b0, $urandom);
    drain(ok);
    checks++;
    if (!ok || txq.size() != 3 || txq[1].setup - txq[0].setup != 4 ||
        txq[2].setup - txq[1].setup != 4) begin
      failures++;
      $display("FAIL b2b_read got n=%0d exp 3 spaced 4", txq.size());
    end
    clear_logs();
    for (int i = 0; i < 3; i++)
      issue(1'b1, AW'($urandom), $urandom, 0, 1'b0, $urandom);
    drain(ok);
    checks++;
    if (!ok || txq.size() != 3 ||
        txq[1].setup - txq[0].setup != (WRSP ? 4 : 3) ||
        txq[2].setup - txq[1].setup != (WRSP ? 4 : 3)) begin
      failures++;
      $display("FAIL b2b_write got n=%0d exp 3 spaced %0d", txq.size(), WRSP ? 4 : 3);
    end
  endtask

  task automatic test_random();
    bit ok;
    int k;
    int n;
    logic [DW+1:0] e;
    k = 0;
    n = 40;
    clear_logs();
    for (int i = 0; i < n; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                      : int'($urandom_range(0, 3));
      issue(1'($urandom), AW'($urandom), $urandom, w, 1'($urandom), $urandom);
    end
    drain(ok);
    checks++;
    if (!ok || txq.size() != n) begin
      failures++;
      $display("FAIL rand_count got ok=%0b n=%0d exp %0d", ok, txq.size(), n);
    end
    for (int i = 0; i < n && i < txq.size(); i++) begin
      checks++;
      if ({txq[i].wr, txq[i].a, txq[i].wd} !== {issq[i].wr, issq[i].a, issq[i].wd} ||
          txq[i].acc != model_acc(issq[i])) begin
        failures++;
        $display("FAIL rand_apb[%0d] got a=%0h acc=%0d exp a=%0h acc=%0d",
                 i, txq[i].a, txq[i].acc, issq[i].a, model_acc(issq[i]));
      end
      if (model_rsp(issq[i], e)) begin
        checks++;
        if (k >= rspq.size() || rspq[k].d !== e ||
            rspq[k].cyc != txq[i].setup + model_acc(issq[i]) + 1) begin
          failures++;
          $display("FAIL rand_rsp[%0d] got %0h exp %0h",
                   i, k < rspq.size() ? rspq[k].d : '0, e);
        end
        k++;
      end
    end
    checks++;
    if (rspq.size() != k || timeout_cnt !== 8'(exp_to) ||
        stab_err != 0 || idle_err != 0) begin
      failures++;
      $display("FAIL rand_summary got rsp=%0d to=%0d stab=%0d idle=%0d exp %0d %0d 0 0",
               rspq.size(), timeout_cnt, stab_err, idle_err, k, exp_to);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int bad;
    bad = 0;
    clear_logs();
    for (int i = 0; i < 260; i++)
      issue(1'b1, AW'($urandom), $urandom, 30, 1'b0, $urandom);
    drain(ok);
    foreach (rspq[i])
      if (rspq[i].d !== {2'b10, 32'h0}) bad++;
    checks++;
    if (!ok || rspq.size() != 260 || bad != 0) begin
      failures++;
      $display("FAIL sat_rsp got ok=%0b n=%0d bad=%0d exp 260 x 10/0",
               ok, rspq.size(), bad);
    end
    checks++;
    if (timeout_cnt !== 8'd255 || exp_to != 255) begin
      failures++;
      $display("FAIL sat_count got %0d exp 255", timeout_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    n = 0;
    clear_logs();
    issue(1'b0, AW'($urandom), $urandom, 10, 1'b0, $urandom);
    while (!(psel && penable) && n < 40) begin
      @(negedge pclk);
      n++;
    end
    checks++;
    if (!(psel && penable)) begin
      failures++;
      $display("FAIL rmid_reach got psel=%b penable=%b exp 1 1", psel, penable);
    end
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, busy} !== 3'b000 || timeout_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rmid_async got psel=%b pen=%b busy=%b to=%0d exp 0",
               psel, penable, busy, timeout_cnt);
    end
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b1;
    exp_to = 0;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if (rspq.size() != 0 || busy !== 1'b0 || psel !== 1'b0) begin
      failures++;
      $display("FAIL rmid_discard got rsp=%0d busy=%b exp 0 0", rspq.size(), busy);
    end
    cmdq.delete();
    slvq.delete();
    clear_logs();
    issue(1'b0, 16'h0042, 32'h0, 1, 1'b0, 32'h1234_5678);
    drain(ok);
    checks++;
    if (!ok || popq.size() != 1 || rspq.size() != 1 ||
        rspq[0].d !== {2'b00, 32'h1234_5678}) begin
      failures++;
      $display("FAIL rmid_next got n=%0d d=%0h exp 1 x 12345678",
               rspq.size(), rspq.size() > 0 ? rspq[0].d : '0);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
